// File: rtl/reg_univ.sv
// Universal register: a WIDTH-bit word that can hold, load, shift, rotate,
// increment or decrement each clock. It has a synchronous preset, a clock
// enable and status flags. SOUT and CARRY are registered. Qbar and ZERO are
// derived combinationally from Q only.
module reg_univ #(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PRESET,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             SOUT,
  output logic             CARRY,
  output logic             ZERO
);

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeLoad = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeShr  = 3'b011;
  localparam logic [2:0] ModeRol  = 3'b100;
  localparam logic [2:0] ModeRor  = 3'b101;
  localparam logic [2:0] ModeInc  = 3'b110;
  localparam logic [2:0] ModeDec  = 3'b111;

  logic [WIDTH-1:0] q_d, q_q;
  logic             sout_d, sout_q;
  logic             carry_d, carry_q;

  // Next-state selection: preset beats enable, and enable beats mode.
  // CARRY is a one-cycle pulse, so it defaults to 0 on every edge.
  always_comb begin
    q_d     = q_q;
    sout_d  = sout_q;
    carry_d = 1'b0;
    if (PRESET) begin
      q_d    = PRESET_VAL;
      sout_d = 1'b0;
    end else if (EN) begin
      unique case (MODE)
        ModeHold: q_d = q_q;
        ModeLoad: q_d = D;
        ModeShl: begin
          q_d    = {q_q[WIDTH-2:0], SIN};
          sout_d = q_q[WIDTH-1];
        end
        ModeShr: begin
          q_d    = {SIN, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        ModeRol: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        ModeRor: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        ModeInc: begin
          q_d     = q_q + WIDTH'(1);
          carry_d = &q_q;
        end
        ModeDec: begin
          q_d     = q_q - WIDTH'(1);
          carry_d = ~|q_q;
        end
        // An unknown MODE must show up as X in simulation and must not be
        // treated as hold.
        default: q_d = {WIDTH{1'bx}};
      endcase
    end
  end

  // State registers with asynchronous reset that overrides everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      sout_q  <= sout_d;
      carry_q <= carry_d;
    end
  end

  assign Q     = q_q;
  assign Qbar  = ~q_q;
  assign SOUT  = sout_q;
  assign CARRY = carry_q;
  assign ZERO  = (q_q == '0);

endmodule

// File: doc/reg_univ.md
# reg_univ

Parametrised universal register: the multi-bit, multi-mode successor to the single-bit preset/reset D flip-flop. It holds a WIDTH-bit word and each clock performs one of eight operations (hold, load, shift, rotate, increment, decrement) with synchronous preset, clock enable and status flags. It is the common storage/shift/count element for the datapath: register file cells, shift units and loop counters.

## Interface

- WIDTH, 32: word width in bits, ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}: value loaded by RST.
- PRESET_VAL, {WIDTH{1'b1}}: value loaded by PRESET.

- CLK  input  1: clock, rising-edge active.
- RST  input  1: asynchronous, active-high reset.
- PRESET  input  1: synchronous preset, active-high.
- EN  input  1: clock enable. 0 holds all state.
- MODE  input  3: operation select, see Operation.
- D  input  WIDTH: parallel load data.
- SIN  input  1: serial input for shifts.
- Q  output  WIDTH: registered word.
- Qbar  output  WIDTH: ~Q, combinational.
- SOUT  output  1: registered; last bit shifted or rotated out.
- CARRY  output  1: registered; one-cycle wrap flag for increment/decrement.
- ZERO  output  1: combinational; 1 when Q == 0.

## Operation

- Reset (RST=1, asynchronous, any time): Q=RESET_VAL, SOUT=0, CARRY=0. Qbar=~RESET_VAL. ZERO follows Q. Holds while RST is 1 and overrides every other input.
- Priority at each rising CLK edge with RST=0: PRESET > EN > MODE.
- PRESET=1: Q=PRESET_VAL, SOUT=0, CARRY=0. Applies regardless of EN.
- EN=0 (PRESET=0): Q and SOUT hold. CARRY is cleared to 0.
- EN=1, MODE:
  - 000 hold: Q holds. SOUT holds.
  - 001 load: Q=D. SOUT holds.
  - 010 shift left: Q={Q[WIDTH-2:0],SIN}; SOUT=Q[WIDTH-1].
  - 011 shift right: Q={SIN,Q[WIDTH-1:1]}; SOUT=Q[0].
  - 100 rotate left: Q={Q[WIDTH-2:0],Q[WIDTH-1]}; SOUT=Q[WIDTH-1].
  - 101 rotate right: Q={Q[0],Q[WIDTH-1:1]}; SOUT=Q[0].
  - 110 increment: Q=Q+1 modulo 2^WIDTH. SOUT holds.
  - 111 decrement: Q=Q-1 modulo 2^WIDTH. SOUT holds.
- CARRY is set to 1 only on an increment from all-ones (wraps to 0) or a decrement from 0 (wraps to all-ones). Every other enabled edge sets it to 0. It is never sticky.
- Arithmetic is unsigned, WIDTH bits. There is no saturation.
- An X or Z on MODE while EN=1 drives Q to X in simulation. It must not be silently decoded as hold.

## Timing

- Latency is one clock: inputs sampled at rising edge N appear on Q, SOUT and CARRY after edge N.
- Qbar and ZERO are combinational from Q and valid in the same cycle as Q.
- RST assertion takes effect immediately without a clock edge.
- RST deassertion: the first operation takes place on the first rising edge where RST is sampled 0.
- Reset mid-operation, for example during an increment sequence: the in-flight result is discarded and Q=RESET_VAL at once.
- PRESET and any MODE asserted together: the preset wins. MODE is ignored for that edge.
- PRESET with RST=1: RST wins.
- No combinational path from any input to any output other than Q to Qbar and Q to ZERO.

## Test plan

All scenarios use WIDTH=8, RESET_VAL=8'h00, PRESET_VAL=8'hFF.

1. Reset and load:
   - RST=1 mid-cycle -> Q=00, Qbar=FF, ZERO=1, CARRY=0 immediately.
   - Release RST, then EN=1, MODE=001, D=A5 -> Q=A5, Qbar=5A, ZERO=0 after one edge.
2. Shift and rotate from Q=A5:
   - Shift left, SIN=1 -> Q=4B, SOUT=1.
   - Shift right, SIN=0 -> Q=25, SOUT=1.
   - Rotate right, four edges -> Q=52, with SOUT=1,0,1,0 in that order.
3. Count wrap:
   - Load FE, then increment twice -> Q=FF with CARRY=0, then Q=00 with CARRY=1 and ZERO=1.
   - One more increment -> Q=01, CARRY=0.
   - From Q=00, decrement -> Q=FF, CARRY=1.
4. Enable and hold:
   - From Q=3C, EN=0 with MODE cycled through all eight codes for 8 edges -> Q stays 3C, SOUT unchanged, CARRY=0.
   - MODE=000 with EN=1 -> Q=3C.
5. Priority:
   - PRESET=1, EN=0 -> Q=FF.
   - PRESET=1 with EN=1, MODE=001, D=12 -> Q=FF.
   - RST=1 and PRESET=1 together -> Q=00.
6. Reset mid-count:
   - Incrementing from 10, assert RST between edges after Q=13 -> Q=00 immediately.
   - Deassert RST -> the first increment gives Q=01.
